// File: rtl/uart_tx_fifo_if.sv
// Push/status bundle between the CPU IO page and uart_tx_fifo.
// FIFO_DEPTH must match the attached uart_tx_fifo so o_level widths agree.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       i_data;
    logic             i_valid;
    logic             o_ready;
    logic             i_clr_ovf;
    logic             o_busy;
    logic [LVL_W-1:0] o_level;
    logic             o_overflow;
    logic             o_uart_tx;

    modport master (
        output i_data, i_valid, i_clr_ovf,
        input  o_ready, o_busy, o_level, o_overflow, o_uart_tx
    );

    modport slave (
        input  i_data, i_valid, i_clr_ovf,
        output o_ready, o_busy, o_level, o_overflow, o_uart_tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular transmit FIFO; frames go out back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_d;
    logic [CNT_W-1:0] baud_cnt, baud_d;
    logic [IDX_W-1:0] bit_idx, bit_idx_d;
    logic [7:0]       shift_reg, shift_d;
    logic             tx_q, tx_d;
    logic             pop;
    logic             bit_end;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             ready;
    logic             push;

    assign ready   = (level != LVL_W'(FIFO_DEPTH));
    assign push    = bus.i_valid && ready;
    assign bit_end = (baud_cnt == CNT_W'(DIV - 1));

    // NOTE: stored bytes need no reset; level gates every read, so stale entries are never sent.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.i_data & DATA_MASK;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // A rejected push outranks a clear in the same cycle.
            if (bus.i_valid && !ready) overflow <= 1'b1;
            else if (bus.i_clr_ovf)    overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_d;
            bit_idx   <= bit_idx_d;
            shift_reg <= shift_d;
            tx_q      <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    parity_q <= 1'b0;
        else if (pop) parity_q <= ^mem[rd_ptr];
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        baud_d    = bit_end ? '0 : baud_cnt + 1'b1;
        bit_idx_d = bit_idx;
        shift_d   = shift_reg;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (level != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d      = shift_reg[0];
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d   = shift_reg >> 1;
                        tx_d      = shift_reg[1];
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (level != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_ready    = ready;
    assign bus.o_level    = level;
    assign bus.o_busy     = (level != '0) || (state != IDLE);
    assign bus.o_overflow = overflow;
    assign bus.o_uart_tx  = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10, FIFO_DEPTH=4; expected line levels are built from hand-derived frames.
module tb_uart_tx_fifo;
    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_tx_fifo_if #(.FIFO_DEPTH(4)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ_HZ(1000000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at the negedge right after the pop edge; returns at the negedge after the stop bit ends.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [11:0] bits;
        int ok;
        int busy_cnt;
        bits      = '0;
        bits[0]   = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9]   = ^b;
`endif
        bits[NBITS - 1] = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < NBITS; k++) begin
            ok = 0;
            for (int c = 0; c < DIV; c++) begin
                if (bus.o_uart_tx === bits[k]) ok++;
                if (bus.o_busy === 1'b1) busy_cnt++;
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, k), ok, DIV);
        end
        check($sformatf("%s_busy", tag), busy_cnt, NBITS * DIV);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_tx"},    bus.o_uart_tx, 1);
        check({tag, "_busy"},  bus.o_busy,    0);
        check({tag, "_level"}, bus.o_level,   0);
    endtask

    // Push one byte into an idle block and follow the resulting frame.
    task automatic send_one(input logic [7:0] b, input string tag);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        check({tag, "_lvl_accept"}, bus.o_level, 1);
        check({tag, "_tx_accept"},  bus.o_uart_tx, 1);
        @(negedge clk);
        check({tag, "_lvl_pop"}, bus.o_level, 0);
        check_frame(b, tag);
        expect_idle({tag, "_end"});
    endtask

    initial begin
        int ok;
        bit [2:0] lv [6];
        lv = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        reset         = 1'b1;
        bus.i_data    = '0;
        bus.i_valid   = 1'b0;
        bus.i_clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx",    bus.o_uart_tx,  1);
        check("rst_ready", bus.o_ready,    1);
        check("rst_busy",  bus.o_busy,     0);
        check("rst_level", bus.o_level,    0);
        check("rst_ovf",   bus.o_overflow, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send_one(8'h55, "f55");
        send_one(8'h07, "f07");
        send_one(8'h03, "f03");

        // Two consecutive pushes: the second lands as the first is popped.
        bus.i_data  = 8'hA3;
        bus.i_valid = 1'b1;
        @(negedge clk);
        check("b2b_lvl0", bus.o_level, 1);
        bus.i_data  = 8'h0F;
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("b2b_lvl1", bus.o_level, 1);
        check_frame(8'hA3, "fA3");
        check("b2b_lvl2", bus.o_level, 0);
        check_frame(8'h0F, "f0F");
        expect_idle("b2b_end");

        // Six pushes against a four-entry FIFO while frame 1 is on the line.
        for (int i = 0; i < 6; i++) begin
            bus.i_data  = 8'(8'h11 + i);
            bus.i_valid = 1'b1;
            @(negedge clk);
            check($sformatf("fill%0d_level", i), bus.o_level, lv[i]);
            check($sformatf("fill%0d_ready", i), bus.o_ready, (lv[i] == 3'd4) ? 0 : 1);
            check($sformatf("fill%0d_ovf", i),   bus.o_overflow, (i == 5) ? 1 : 0);
            if (i == 1) check("fill_tx_start", bus.o_uart_tx, 0);
        end
        bus.i_valid   = 1'b0;
        bus.i_clr_ovf = 1'b1;
        @(negedge clk);
        bus.i_clr_ovf = 1'b0;
        check("clr_ovf", bus.o_overflow, 0);
        repeat (94) @(negedge clk);
        check("pre_stop_level", bus.o_level, 4);
        check("pre_stop_ready", bus.o_ready, 0);
        check("pre_stop_tx",    bus.o_uart_tx, 1);

        // Push and clear collide with the stop-end pop: push dropped, set beats clear.
        bus.i_data    = 8'h77;
        bus.i_valid   = 1'b1;
        bus.i_clr_ovf = 1'b1;
        @(negedge clk);
        bus.i_valid   = 1'b0;
        check("pp_level", bus.o_level,    3);
        check("pp_ready", bus.o_ready,    1);
        check("pp_ovf",   bus.o_overflow, 1);
        check_frame(8'h12, "f12");
        bus.i_clr_ovf = 1'b0;
        check("pp_ovf_clr", bus.o_overflow, 0);
        check_frame(8'h13, "f13");
        check_frame(8'h14, "f14");
        check_frame(8'h15, "f15");
        expect_idle("fill_end");
        ok = 0;
        for (int c = 0; c < 3 * NBITS * DIV; c++) begin
            if (bus.o_uart_tx === 1'b1 && bus.o_busy === 1'b0) ok++;
            @(negedge clk);
        end
        check("fill_no_extra", ok, 3 * NBITS * DIV);

        // Reset in the middle of bit 4 with another byte still queued.
        bus.i_data  = 8'h00;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_data  = 8'hFF;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (45) @(negedge clk);
        check("mid_tx_low", bus.o_uart_tx, 0);
        check("mid_busy",   bus.o_busy,    1);
        #2 reset = 1'b1;
        #1;
        check("arst_tx",    bus.o_uart_tx, 1);
        check("arst_level", bus.o_level,   0);
        check("arst_busy",  bus.o_busy,    0);
        check("arst_ready", bus.o_ready,   1);
        @(negedge clk);
        reset = 1'b0;
        ok = 0;
        for (int c = 0; c < 3 * NBITS * DIV; c++) begin
            @(negedge clk);
            if (bus.o_uart_tx === 1'b1 && bus.o_busy === 1'b0) ok++;
        end
        check("post_rst_quiet", ok, 3 * NBITS * DIV);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
